// File: rtl/pcs_pkg.sv
// Shared constants and types for the 1000BASE-X PCS receive end-of-packet checker.
// Code-group values are the decoded octets; K/D distinction travels separately.
package pcs_pkg;

   localparam logic [7:0] K28_5       = 8'hBC;
   localparam logic [7:0] SOP         = 8'hFB;
   localparam logic [7:0] EOP         = 8'hFD;
   localparam logic [7:0] CARRIER_EXT = 8'hF7;
   localparam logic [7:0] D21_5       = 8'hB5;
   localparam logic [7:0] D2_2        = 8'h42;
   localparam logic [7:0] D0_0        = 8'h00;

   // Frame tracking state, also exported on the state port for observation.
   typedef logic [1:0] frame_state_t;

   localparam frame_state_t ST_IDLE   = 2'd0;
   localparam frame_state_t ST_PACKET = 2'd1;
   localparam frame_state_t ST_EXTEND = 2'd2;

   // True when the code-group is the control symbol with value v.
   function automatic logic is_k(input logic [7:0] d, input logic k, input logic [7:0] v);
      return k && (d == v);
   endfunction

   // True when the code-group is the data symbol with value v.
   function automatic logic is_d(input logic [7:0] d, input logic k, input logic [7:0] v);
      return !k && (d == v);
   endfunction

endpackage

// File: rtl/cg_window.sv
// Valid-gated code-group shift window with fill counter.
// Entry 0 is the newest, entry WIN-1 the oldest. The three oldest entries and
// the full flag are presented as they will be after the current edge, so the
// parent can register decisions in step with the shifted window.
// Optional feature macro: CHECK_END_EARLY_END_EN (adds rx_even storage).
module cg_window
   import pcs_pkg::*;
#(
   parameter int WIN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       shift,
   input  logic [7:0] in_data,
   input  logic       in_datak,
`ifdef CHECK_END_EARLY_END_EN
   input  logic       in_even,
   output logic       c_even,
`endif
   output logic [7:0] a_data,
   output logic       a_datak,
   output logic [7:0] b_data,
   output logic       b_datak,
   output logic [7:0] c_data,
   output logic       c_datak,
   output logic       full,
   output logic [7:0] old_data,
   output logic       old_datak
);

   localparam int FW = $clog2(WIN + 1);
   localparam logic [FW-1:0] FILL_MAX = FW'(WIN);

   logic [WIN-1:0][7:0] w_data;
   logic [WIN-1:0][7:0] n_data;
   logic [WIN-1:0]      w_datak;
   logic [WIN-1:0]      n_datak;
   logic [FW-1:0]       fill;
   logic [FW-1:0]       n_fill;

   // Next window contents: shift in the new code-group only when accepted.
   always_comb begin
      n_data  = w_data;
      n_datak = w_datak;
      n_fill  = fill;
      if (shift) begin
         n_data  = {w_data[WIN-2:0], in_data};
         n_datak = {w_datak[WIN-2:0], in_datak};
         if (fill != FILL_MAX) n_fill = fill + 1'b1;
      end
   end

   // Window and fill registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_data  <= '0;
         w_datak <= '0;
         fill    <= '0;
      end else begin
         w_data  <= n_data;
         w_datak <= n_datak;
         fill    <= n_fill;
      end
   end

`ifdef CHECK_END_EARLY_END_EN
   logic [WIN-1:0] w_even;
   logic [WIN-1:0] n_even;

   // Alignment flag travels alongside each stored code-group.
   always_comb begin
      n_even = w_even;
      if (shift) n_even = {w_even[WIN-2:0], in_even};
   end

   // Alignment flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) w_even <= '0;
      else     w_even <= n_even;
   end

   assign c_even = n_even[WIN-3];
`endif

   assign a_data    = n_data[WIN-1];
   assign a_datak   = n_datak[WIN-1];
   assign b_data    = n_data[WIN-2];
   assign b_datak   = n_datak[WIN-2];
   assign c_data    = n_data[WIN-3];
   assign c_datak   = n_datak[WIN-3];
   assign full      = (n_fill == FILL_MAX);
   assign old_data  = w_data[WIN-1];
   assign old_datak = w_datak[WIN-1];

endmodule

// File: rtl/pcs_rx_check_end.sv
// Receive-side end-of-packet checker for the 1000BASE-X PCS.
// Flags /T/R/R/, /T/R/I/, /R/R/R/, /R/R/S/ and early-end patterns starting at
// the oldest window entry, tracks frame state and measures carrier extension.
// Optional feature macro: CHECK_END_EARLY_END_EN (early_end decode and
// PACKET abort with frame_err); undefined leaves early_end/frame_err at 0.
//
// Handshake: in_valid qualifies data/datak/rx_even for exactly one cycle and
// there is no backpressure. out_valid is high for the single cycle after each
// accepted code-group once the window is full; every flag and pulse is only
// ever high together with out_valid.
module pcs_rx_check_end
   import pcs_pkg::*;
#(
   parameter int WIN       = 3,
   parameter int EXT_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [7:0]           data,
   input  logic                 datak,
   input  logic                 rx_even,
   output logic                 out_valid,
   output logic [7:0]           out_data,
   output logic                 out_datak,
   output logic                 t_r_r,
   output logic                 t_r_i,
   output logic                 r_r_r,
   output logic                 r_r_s,
   output logic                 early_end,
   output logic [EXT_CNT_W-1:0] ext_len,
   output logic                 ext_done,
   output logic                 frame_err,
   output logic [1:0]           state
);

   localparam logic [EXT_CNT_W-1:0] CNT_MAX = '1;

   logic [7:0]           a_data, b_data, c_data;
   logic                 a_k, b_k, c_k;
   logic                 win_full;
   logic                 acc;
   logic                 p_trr, p_tri, p_rrr, p_rrs, p_ee;
   frame_state_t         st_d;
   logic [EXT_CNT_W-1:0] cnt_q, cnt_d, len_d;
   logic                 done_d, err_d;

`ifdef CHECK_END_EARLY_END_EN
   logic c_even;
`endif

   cg_window #(.WIN(WIN)) u_window (
      .clk       (clk),
      .rst       (rst),
      .shift     (in_valid),
      .in_data   (data),
      .in_datak  (datak),
`ifdef CHECK_END_EARLY_END_EN
      .in_even   (rx_even),
      .c_even    (c_even),
`endif
      .a_data    (a_data),
      .a_datak   (a_k),
      .b_data    (b_data),
      .b_datak   (b_k),
      .c_data    (c_data),
      .c_datak   (c_k),
      .full      (win_full),
      .old_data  (out_data),
      .old_datak (out_datak)
   );

   // An edge is a decision point only when it accepts data into a full window.
   assign acc = in_valid & win_full;

   assign p_trr = is_k(a_data, a_k, EOP) & is_k(b_data, b_k, CARRIER_EXT) &
                  is_k(c_data, c_k, CARRIER_EXT);
   assign p_tri = is_k(a_data, a_k, EOP) & is_k(b_data, b_k, CARRIER_EXT) &
                  is_k(c_data, c_k, K28_5);
   assign p_rrr = is_k(a_data, a_k, CARRIER_EXT) & is_k(b_data, b_k, CARRIER_EXT) &
                  is_k(c_data, c_k, CARRIER_EXT);
   assign p_rrs = is_k(a_data, a_k, CARRIER_EXT) & is_k(b_data, b_k, CARRIER_EXT) &
                  is_k(c_data, c_k, SOP);

`ifdef CHECK_END_EARLY_END_EN
   // Comma followed by data then comma, or comma + D21.5/D2.2 + D0.0 on even.
   assign p_ee = is_k(a_data, a_k, K28_5) &
                 ((!b_k & is_k(c_data, c_k, K28_5)) |
                  ((is_d(b_data, b_k, D21_5) | is_d(b_data, b_k, D2_2)) &
                   is_d(c_data, c_k, D0_0) & c_even));
`else
   logic unused_rx_even;
   assign unused_rx_even = rx_even;
   assign p_ee = 1'b0;
`endif

   // Frame state, extension counter and pulse decisions for this edge.
   always_comb begin
      st_d   = state;
      cnt_d  = cnt_q;
      len_d  = ext_len;
      done_d = 1'b0;
      err_d  = 1'b0;
      if (acc) begin
         case (state)
            ST_IDLE: begin
               if (is_k(a_data, a_k, SOP)) st_d = ST_PACKET;
            end
            ST_PACKET: begin
               // End-of-packet wins over an early-end seen on the same triple.
               if (p_trr | p_tri) begin
                  st_d  = ST_EXTEND;
                  cnt_d = '0;
               end else if (p_ee) begin
                  st_d  = ST_IDLE;
                  err_d = 1'b1;
               end
            end
            ST_EXTEND: begin
               if (is_k(a_data, a_k, CARRIER_EXT)) begin
                  if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
               end else begin
                  done_d = 1'b1;
                  len_d  = cnt_q;
                  st_d   = is_k(a_data, a_k, SOP) ? ST_PACKET : ST_IDLE;
               end
            end
            default: st_d = ST_IDLE;
         endcase
      end
   end

   // Registered outputs; flags and pulses exist only on accepting edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         t_r_r     <= 1'b0;
         t_r_i     <= 1'b0;
         r_r_r     <= 1'b0;
         r_r_s     <= 1'b0;
         early_end <= 1'b0;
         ext_done  <= 1'b0;
         frame_err <= 1'b0;
         ext_len   <= '0;
         cnt_q     <= '0;
         state     <= ST_IDLE;
      end else begin
         out_valid <= acc;
         t_r_r     <= acc & p_trr;
         t_r_i     <= acc & p_tri;
         r_r_r     <= acc & p_rrr;
         r_r_s     <= acc & p_rrs;
         early_end <= acc & p_ee;
         ext_done  <= done_d;
         frame_err <= err_d;
         ext_len   <= len_d;
         cnt_q     <= cnt_d;
         state     <= st_d;
      end
   end

endmodule

// File: tb/tb_pcs_rx_check_end.sv
// Bench for pcs_rx_check_end: two instances (WIN=3/EXT_CNT_W=8 and
// WIN=5/EXT_CNT_W=2) driven by the same directed code-group stream.
module tb_pcs_rx_check_end;

   localparam logic [7:0] C_I = 8'hBC;
   localparam logic [7:0] C_S = 8'hFB;
   localparam logic [7:0] C_T = 8'hFD;
   localparam logic [7:0] C_R = 8'hF7;

`ifdef CHECK_END_EARLY_END_EN
   localparam int EE_ON = 1;
`else
   localparam int EE_ON = 0;
`endif

   localparam int W0 = 3, MAX0 = 255;
   localparam int W1 = 5, MAX1 = 3;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] data = 8'h00;
   logic       datak = 1'b0;
   logic       rx_even = 1'b0;
   logic       gap_mode = 1'b0;

   always #5 clk = ~clk;

   logic       u0_out_valid, u0_out_datak, u0_t_r_r, u0_t_r_i, u0_r_r_r, u0_r_r_s;
   logic       u0_early_end, u0_ext_done, u0_frame_err;
   logic [7:0] u0_out_data, u0_ext_len;
   logic [1:0] u0_state;
   logic       u1_out_valid, u1_out_datak, u1_t_r_r, u1_t_r_i, u1_r_r_r, u1_r_r_s;
   logic       u1_early_end, u1_ext_done, u1_frame_err;
   logic [7:0] u1_out_data;
   logic [1:0] u1_ext_len;
   logic [1:0] u1_state;

   pcs_rx_check_end #(.WIN(W0), .EXT_CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data(data), .datak(datak),
      .rx_even(rx_even), .out_valid(u0_out_valid), .out_data(u0_out_data),
      .out_datak(u0_out_datak), .t_r_r(u0_t_r_r), .t_r_i(u0_t_r_i),
      .r_r_r(u0_r_r_r), .r_r_s(u0_r_r_s), .early_end(u0_early_end),
      .ext_len(u0_ext_len), .ext_done(u0_ext_done), .frame_err(u0_frame_err),
      .state(u0_state)
   );

   pcs_rx_check_end #(.WIN(W1), .EXT_CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data(data), .datak(datak),
      .rx_even(rx_even), .out_valid(u1_out_valid), .out_data(u1_out_data),
      .out_datak(u1_out_datak), .t_r_r(u1_t_r_r), .t_r_i(u1_t_r_i),
      .r_r_r(u1_r_r_r), .r_r_s(u1_r_r_s), .early_end(u1_early_end),
      .ext_len(u1_ext_len), .ext_done(u1_ext_done), .frame_err(u1_frame_err),
      .state(u1_state)
   );

   // ---------------- reference model ----------------
   typedef struct packed { logic [7:0] d; logic k; logic e; } cg_t;
   typedef struct packed {
      logic       v;
      logic [7:0] d;
      logic       k;
      logic       f_trr, f_tri, f_rrr, f_rrs, ee, done, fe;
      logic [1:0] st;
      logic [7:0] len;
   } obs_t;

   cg_t  hist[$];
   obs_t exp_o [2];
   int   m_st [2];
   int   m_cnt [2];

   function automatic bit isk(input cg_t c, input logic [7:0] v);
      return c.k && (c.d == v);
   endfunction

   function automatic bit isd(input cg_t c, input logic [7:0] v);
      return !c.k && (c.d == v);
   endfunction

   // The oldest WIN-th accepted code-group is what the window shows at its far end.
   task automatic model_step(input int u, input int win, input int maxc);
      obs_t o;
      cg_t  a, b, c;
      int   n;
      o = exp_o[u];
      o.v = 0; o.f_trr = 0; o.f_tri = 0; o.f_rrr = 0; o.f_rrs = 0;
      o.ee = 0; o.done = 0; o.fe = 0;
      n = hist.size();
      if (in_valid && n >= win) begin
         a = hist[n-win];
         b = hist[n-win+1];
         c = hist[n-win+2];
         o.v = 1; o.d = a.d; o.k = a.k;
         o.f_trr = isk(a, C_T) && isk(b, C_R) && isk(c, C_R);
         o.f_tri = isk(a, C_T) && isk(b, C_R) && isk(c, C_I);
         o.f_rrr = isk(a, C_R) && isk(b, C_R) && isk(c, C_R);
         o.f_rrs = isk(a, C_R) && isk(b, C_R) && isk(c, C_S);
         o.ee = (EE_ON != 0) &&
                ((isk(a, C_I) && !b.k && isk(c, C_I)) ||
                 (isk(a, C_I) && (isd(b, 8'hB5) || isd(b, 8'h42)) && isd(c, 8'h00) && c.e));
         case (m_st[u])
            0: if (isk(a, C_S)) m_st[u] = 1;
            1: begin
               if (o.f_trr || o.f_tri) begin m_st[u] = 2; m_cnt[u] = 0; end
               else if (o.ee) begin m_st[u] = 0; o.fe = 1; end
            end
            2: begin
               if (isk(a, C_R)) m_cnt[u] = (m_cnt[u] < maxc) ? m_cnt[u] + 1 : maxc;
               else begin
                  o.done = 1;
                  o.len  = 8'(m_cnt[u]);
                  m_st[u] = isk(a, C_S) ? 1 : 0;
               end
            end
            default: m_st[u] = 0;
         endcase
      end
      o.st = 2'(m_st[u]);
      exp_o[u] = o;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hist.delete();
         for (int u = 0; u < 2; u++) begin
            m_st[u] = 0; m_cnt[u] = 0; exp_o[u] = '0;
         end
      end else begin
         if (in_valid) hist.push_back('{d: data, k: datak, e: rx_even});
         model_step(0, W0, MAX0);
         model_step(1, W1, MAX1);
      end
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q0[$];
   logic [9:0] exp_q1[$];
   int n_trr, n_tri, n_rrr, n_rrs, n_ee, n_fe, n_done;
   logic [7:0] last_trr_data, last_done_data;
   obs_t g0, g1;
   logic [9:0] qe;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic cmp_obs(input string nm, input obs_t g, input obs_t e);
      obs_t gm, em;
      gm = g; em = e;
      if (!em.done) begin gm.len = '0; em.len = '0; end
      checks++;
      if (gm !== em) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, gm, em, $time);
      end
   endtask

   // Per-cycle comparison against the model, plus literal extension results.
   always @(negedge clk) begin
      g0 = {u0_out_valid, u0_out_data, u0_out_datak, u0_t_r_r, u0_t_r_i, u0_r_r_r,
            u0_r_r_s, u0_early_end, u0_ext_done, u0_frame_err, u0_state, u0_ext_len};
      g1 = {u1_out_valid, u1_out_data, u1_out_datak, u1_t_r_r, u1_t_r_i, u1_r_r_r,
            u1_r_r_s, u1_early_end, u1_ext_done, u1_frame_err, u1_state, 6'b0, u1_ext_len};
      cmp_obs("u0_cycle", g0, exp_o[0]);
      cmp_obs("u1_cycle", g1, exp_o[1]);
      if (u0_ext_done) begin
         if (exp_q0.size() == 0) chk("u0_ext_unexpected", {22'b0, u0_state, u0_ext_len}, 32'hFFFF_FFFF);
         else begin
            qe = exp_q0.pop_front();
            chk("u0_ext_state_len", {22'b0, u0_state, u0_ext_len}, {22'b0, qe});
         end
      end
      if (u1_ext_done) begin
         if (exp_q1.size() == 0) chk("u1_ext_unexpected", {22'b0, u1_state, 6'b0, u1_ext_len}, 32'hFFFF_FFFF);
         else begin
            qe = exp_q1.pop_front();
            chk("u1_ext_state_len", {22'b0, u1_state, 6'b0, u1_ext_len}, {22'b0, qe});
         end
      end
      if (u0_t_r_r) begin n_trr++; last_trr_data = u0_out_data; end
      if (u0_t_r_i) n_tri++;
      if (u0_r_r_r) n_rrr++;
      if (u0_r_r_s) n_rrs++;
      if (u0_early_end) n_ee++;
      if (u0_frame_err) n_fe++;
      if (u0_ext_done) begin n_done++; last_done_data = u0_out_data; end
   end

   task automatic clr_tally();
      n_trr = 0; n_tri = 0; n_rrr = 0; n_rrs = 0; n_ee = 0; n_fe = 0; n_done = 0;
      last_trr_data = 8'h00; last_done_data = 8'h00;
   endtask

   task automatic check_tally(input string nm, input int trr, input int tri_c, input int rrr,
                              input int rrs, input int ee, input int fe, input int done);
      chk({nm, "_trr"}, n_trr, trr);
      chk({nm, "_tri"}, n_tri, tri_c);
      chk({nm, "_rrr"}, n_rrr, rrr);
      chk({nm, "_rrs"}, n_rrs, rrs);
      chk({nm, "_ee"}, n_ee, ee);
      chk({nm, "_fe"}, n_fe, fe);
      chk({nm, "_done"}, n_done, done);
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [7:0] d, input logic k, input logic e);
      in_valid = 1'b1; data = d; datak = k; rx_even = e;
      @(negedge clk);
      if (gap_mode) begin
         in_valid = 1'b0;
         data     = 8'($urandom_range(0, 255));
         datak    = 1'($urandom_range(0, 1));
         rx_even  = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic sk(input logic [7:0] d);
      send(d, 1'b1, 1'b0);
   endtask

   task automatic sd(input logic [7:0] d);
      send(d, 1'b0, 1'b0);
   endtask

   task automatic idles(input int n);
      for (int i = 0; i < n; i++) sk(C_I);
   endtask

   task automatic seq_t1();
      sk(C_S); sd(8'h55); sd(8'h55); sk(C_T); sk(C_R); sk(C_R); sk(C_I);
      idles(7);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      clr_tally();
      repeat (2) @(negedge clk);
      chk("rst_u0_state", u0_state, 0);
      chk("rst_u0_valid", u0_out_valid, 0);
      chk("rst_u0_data", u0_out_data, 0);
      chk("rst_u0_len", u0_ext_len, 0);
      rst = 1'b0;
      idles(7);

      // S D D T R R I: extension of two /R/
      clr_tally();
      exp_q0.push_back({2'd0, 8'd2}); exp_q1.push_back({2'd0, 8'd2});
      seq_t1();
      check_tally("t1", 1, 0, 0, 0, 0, 0, 1);
      chk("t1_trr_data", last_trr_data, 8'hFD);
      chk("t1_done_data", last_done_data, 8'hBC);
      chk("t1_end_state", u0_state, 0);

      // S T R I
      clr_tally();
      exp_q0.push_back({2'd0, 8'd1}); exp_q1.push_back({2'd0, 8'd1});
      sk(C_S); sk(C_T); sk(C_R); sk(C_I); idles(7);
      check_tally("t2", 0, 1, 0, 0, 0, 0, 1);

      // S T R R R R S D T R I: extension ends on /S/, back into PACKET
      clr_tally();
      exp_q0.push_back({2'd1, 8'd4}); exp_q0.push_back({2'd0, 8'd1});
      exp_q1.push_back({2'd1, 8'd3}); exp_q1.push_back({2'd0, 8'd1});
      sk(C_S); sk(C_T); sk(C_R); sk(C_R); sk(C_R); sk(C_R); sk(C_S); sd(8'h55);
      sk(C_T); sk(C_R); sk(C_I); idles(7);
      check_tally("t3", 1, 1, 2, 1, 0, 0, 2);

      // S T R x5 I: 2-bit counter saturates at 3
      clr_tally();
      exp_q0.push_back({2'd0, 8'd5}); exp_q1.push_back({2'd0, 8'd3});
      sk(C_S); sk(C_T); repeat (5) sk(C_R); sk(C_I); idles(7);
      check_tally("sat", 1, 0, 3, 0, 0, 0, 1);

      // Early end: comma, data, comma inside a packet
      clr_tally();
      if (EE_ON == 0) begin exp_q0.push_back({2'd0, 8'd1}); exp_q1.push_back({2'd0, 8'd1}); end
      sk(C_S); sd(8'h55); sk(C_I); sd(8'h50); sk(C_I); sk(C_T); sk(C_R); sk(C_I); idles(7);
      check_tally("ee1", 0, 1, 0, 0, EE_ON, EE_ON, 1 - EE_ON);
      chk("ee1_state", u0_state, 0);

      // Early end: comma, D21.5, D0.0 on even alignment
      clr_tally();
      if (EE_ON == 0) begin exp_q0.push_back({2'd0, 8'd1}); exp_q1.push_back({2'd0, 8'd1}); end
      sk(C_S); sk(C_I); sd(8'hB5); send(8'h00, 1'b0, 1'b1); sk(C_T); sk(C_R); sk(C_I); idles(7);
      check_tally("ee2", 0, 1, 0, 0, EE_ON, EE_ON, 1 - EE_ON);

      // Early end: comma, D2.2, D0.0 on even alignment
      clr_tally();
      if (EE_ON == 0) begin exp_q0.push_back({2'd0, 8'd1}); exp_q1.push_back({2'd0, 8'd1}); end
      sk(C_S); sk(C_I); sd(8'h42); send(8'h00, 1'b0, 1'b1); sk(C_T); sk(C_R); sk(C_I); idles(7);
      check_tally("ee2b", 0, 1, 0, 0, EE_ON, EE_ON, 1 - EE_ON);

      // Same pattern on odd alignment is not an early end
      clr_tally();
      exp_q0.push_back({2'd0, 8'd1}); exp_q1.push_back({2'd0, 8'd1});
      sk(C_S); sk(C_I); sd(8'hB5); send(8'h00, 1'b0, 1'b0); sk(C_T); sk(C_R); sk(C_I); idles(7);
      check_tally("ee3", 0, 1, 0, 0, 0, 0, 1);

      // First sequence again with idle cycles between every code-group
      gap_mode = 1'b1;
      clr_tally();
      exp_q0.push_back({2'd0, 8'd2}); exp_q1.push_back({2'd0, 8'd2});
      seq_t1();
      check_tally("gap", 1, 0, 0, 0, 0, 0, 1);
      chk("gap_trr_data", last_trr_data, 8'hFD);
      gap_mode = 1'b0;

      // Reset while both instances are extending
      clr_tally();
      sk(C_S); sk(C_T); sk(C_R); sk(C_R); sk(C_R); sk(C_R);
      chk("pre_rst_u0_state", u0_state, 2);
      chk("pre_rst_u1_state", u1_state, 2);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_u0_state", u0_state, 0);
      chk("rst_mid_u1_state", u1_state, 0);
      chk("rst_mid_u0_valid", u0_out_valid, 0);
      chk("rst_mid_u0_data", u0_out_data, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sk(C_I); sk(C_I);
      chk("refill_u0_low", u0_out_valid, 0);
      sk(C_I);
      chk("refill_u0_high", u0_out_valid, 1);
      chk("refill_u1_low", u1_out_valid, 0);
      idles(5);
      check_tally("rst", 1, 0, 2, 0, 0, 0, 0);

      chk("exp_q0_empty", exp_q0.size(), 0);
      chk("exp_q1_empty", exp_q1.size(), 0);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcs_rx_check_end.md
# pcs_rx_check_end

Parametrised receive-side end-of-packet checker for the 1000BASE-X PCS. It sits between code-group alignment/decoding and the receive state machine. It buffers a sliding window of decoded code-groups and flags the /T/R/R/, /T/R/I/, /R/R/R/, /R/R/S/ and early-end (check_end) patterns, aligned to a delayed copy of the stream. It also tracks frame state and measures carrier-extension length.

## Interface
- WIN, 3, window depth in code-groups (3..8); also the stream delay in accepted code-groups
- EXT_CNT_W, 8, width of the carrier-extension length counter
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  data/datak/rx_even carry a code-group this cycle
- data  in  8  decoded code-group
- datak  in  1  1 = control (K) code-group
- rx_even  in  1  even-alignment flag from synchronisation
- out_valid  out  1  out_* and flags valid this cycle
- out_data  out  8  oldest window entry
- out_datak  out  1  K flag of oldest entry
- t_r_r, t_r_i, r_r_r, r_r_s  out  1 each  pattern starting at out_data (oldest, mid, newest of the three oldest entries)
- early_end  out  1  check_end pattern starting at out_data
- ext_len  out  EXT_CNT_W  carrier-extension length, valid with ext_done
- ext_done  out  1  one-cycle pulse: extension ended
- frame_err  out  1  one-cycle pulse: packet aborted by early_end
- state  out  2  frame state: 0 IDLE, 1 PACKET, 2 EXTEND

## Operation
- Window w[0] (newest) .. w[WIN-1] (oldest); each entry stores data, datak and rx_even. It shifts only when in_valid=1.
- A fill counter tracks entries. out_valid=0 until WIN code-groups are accepted after reset.
- Triple = (w[WIN-1], w[WIN-2], w[WIN-3]) = (A, B, C). All symbols below are K except D-groups:
  - t_r_r: A=/T/ FD, B=/R/ F7, C=/R/
  - t_r_i: A=/T/, B=/R/, C=K28.5 BC
  - r_r_r: A, B and C all /R/
  - r_r_s: A=/R/, B=/R/, C=/S/ FB
  - early_end: A=K28.5 with B any D-group and C=K28.5; or A=K28.5, B=D21.5 B5 or D2.2 42 (both D), C=D0.0 00 (D), and the rx_even stored with C =1
- FSM, evaluated on the new window at each accepting edge:
  - IDLE: A=/S/ → PACKET
  - PACKET: t_r_r or t_r_i → EXTEND, and the counter clears to 0. Otherwise early_end → IDLE with frame_err=1.
  - EXTEND: A=/R/ → counter +1, saturating at 2^EXT_CNT_W−1. A not /R/ → ext_done=1 and ext_len=counter. Next state is PACKET if A=/S/, else IDLE.
- The t_r_r/t_r_i check takes priority over early_end in the same cycle.
- All flags and pulses are gated by out_valid.

## Timing
- All outputs are registered. Flags, state, ext_* and out_data update on the same edge, from the post-shift window.
- A code-group accepted on edge n appears on out_data after edge n+WIN−1, counted in accepting edges.
- out_valid=1 for exactly the cycle after each accepting edge once the window is full. Otherwise it is 0, and all pulses are 0.
- When in_valid=0: the window, counter and state hold; out_data holds; pulses are 0.
- Reset values: window entries 00/0/0, fill 0, state IDLE, counter 0, and every output 0.
- Reset mid-frame aborts immediately, with no ext_done and no frame_err.
- Reset deassertion requires a full refill before out_valid rises again.

## Configuration
- CHECK_END_EARLY_END_EN defined: the early_end pattern is decoded, and PACKET aborts on it with frame_err.
- Undefined: early_end and frame_err are tied 0. The rx_even storage is omitted and PACKET is left only via /T/R/.

## Structure
- Package pcs_pkg holds:
  - constants K28_5=8'hBC, SOP=8'hFB, EOP=8'hFD, CARRIER_EXT=8'hF7, D21_5=8'hB5, D2_2=8'h42, D0_0=8'h00
  - typedef for the 2-bit frame state
- Sub-module cg_window: WIN-deep valid-gated shift register with fill counter. It exposes the three oldest entries and the full flag.

## Test plan
- WIN=3, stream S,D(55),D(55),T,R,R,I (K except D): t_r_r with out_data=FD; state goes PACKET→EXTEND; ext_done with ext_len=2 when out_data=BC; state → IDLE.
- T,R,I after /S/: t_r_i=1, ext_len=1, state IDLE.
- T,R,R,R,R,S: r_r_r on the first two oldest R, r_r_s on the third; ext_len=4; state → PACKET.
- With _EN defined, in PACKET:
  - BC(K),50(D),BC(K): early_end=1, frame_err=1, state IDLE
  - BC,B5,00 (D) with rx_even=1: early_end=1
  - the same with rx_even=0: early_end=0
- EXT_CNT_W=2, T then 5×R then I: ext_len saturates at 3.
- in_valid toggling 1/0 throughout test 1 gives identical flags, counts and pulses on valid cycles only. Reset asserted in EXTEND: all outputs 0 and state IDLE, with no ext_done.
